// File: rtl/cfu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfu_pkg : shared types and helpers for the custom-0 sequencer  | rev 1.0
// ---------------------------------------------------------------------------
package cfu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUB  = 3'd1,
    S_MUL  = 3'd2,
    S_ADD  = 3'd3,
    S_IACC = 3'd4,
    S_RESP = 3'd5
  } state_t;

  localparam logic [2:0] F3_MAC  = 3'd0;
  localparam logic [2:0] F3_DSQA = 3'd2;

  // Subtraction on the adder is done by flipping the IEEE-754 sign bit.
  function automatic logic [31:0] fp_neg(input logic [31:0] x);
    return {~x[31], x[30:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfu_wdt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfu_wdt : 8-bit request watchdog, flags the TIMEOUT-th unacked cycle | rev 1.0
// ---------------------------------------------------------------------------
module cfu_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of earlier unacked cycles, so this cycle is the TIMEOUT-th
  assign expired = en & (count == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/cfu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfu_seq : custom-0 sequencer, DSQA / MAC16 over shared FP adder + multiplier | rev 1.0
// ---------------------------------------------------------------------------
module cfu_seq
  import cfu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        flush,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [2:0]  ins_funct3,
  input  logic [31:0] ins_rs1,
  input  logic [31:0] ins_rs2,
  input  logic [31:0] ins_acc,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        fadd_req,
  output logic [31:0] fadd_a,
  output logic [31:0] fadd_b,
  input  logic        fadd_ack,
  input  logic [31:0] fadd_res,
  output logic        fmul_req,
  output logic        fmul_int,
  output logic [31:0] fmul_a,
  output logic [31:0] fmul_b,
  input  logic        fmul_ack,
  input  logic [31:0] fmul_res,
  output logic        busy
);

  state_t      state;
  logic [31:0] acc;
  logic [31:0] prod;
  logic        mac_op;

  logic fadd_take;
  logic fmul_take;
  logic wdt_en;
  logic wdt_clr;
  logic wdt_expired;

  // Acks are only honoured while the matching request is outstanding.
  assign fadd_take = fadd_req & fadd_ack;
  assign fmul_take = fmul_req & fmul_ack;

  // Counting restarts whenever a request completes or none is pending, i.e. on each state entry.
  assign wdt_en  = (fadd_req & ~fadd_ack) | (fmul_req & ~fmul_ack);
  assign wdt_clr = flush | fadd_take | fmul_take | ~(fadd_req | fmul_req);

  cfu_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (wdt_clr),
    .en      (wdt_en),
    .expired (wdt_expired)
  );

  assign ins_ready = (state == S_IDLE) & ~flush;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      acc       <= 32'd0;
      prod      <= 32'd0;
      mac_op    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_err   <= 1'b0;
      fadd_req  <= 1'b0;
      fadd_a    <= 32'd0;
      fadd_b    <= 32'd0;
      fmul_req  <= 1'b0;
      fmul_int  <= 1'b0;
      fmul_a    <= 32'd0;
      fmul_b    <= 32'd0;
    end else if (flush) begin
      state     <= S_IDLE;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      fadd_req  <= 1'b0;
      fmul_req  <= 1'b0;
      fmul_int  <= 1'b0;
    end else if (wdt_expired) begin
      state     <= S_RESP;
      fadd_req  <= 1'b0;
      fmul_req  <= 1'b0;
      res_valid <= 1'b1;
      res_err   <= 1'b1;
      res_data  <= acc;
    end else begin
      case (state)
        S_IDLE: begin
          if (ins_valid) begin
            acc    <= ins_acc;
            mac_op <= (ins_funct3 == F3_MAC);
            case (ins_funct3)
              F3_DSQA: begin
                state    <= S_SUB;
                fadd_req <= 1'b1;
                fadd_a   <= ins_rs1;
                fadd_b   <= fp_neg(ins_rs2);
              end
              F3_MAC: begin
                state    <= S_MUL;
                fmul_req <= 1'b1;
                fmul_int <= 1'b1;
                fmul_a   <= {16'd0, ins_rs1[15:0]};
                fmul_b   <= {16'd0, ins_rs2[15:0]};
              end
              default: begin
                state     <= S_RESP;
                res_valid <= 1'b1;
                res_err   <= 1'b1;
                res_data  <= ins_acc;
              end
            endcase
          end
        end

        S_SUB: begin
          if (fadd_take) begin
            state    <= S_MUL;
            fadd_req <= 1'b0;
            fmul_req <= 1'b1;
            fmul_int <= 1'b0;
            fmul_a   <= fadd_res;
            fmul_b   <= fadd_res;
          end
        end

        S_MUL: begin
          if (fmul_take) begin
            fmul_req <= 1'b0;
            fmul_int <= 1'b0;
            prod     <= fmul_res;
            if (mac_op) begin
              state <= S_IACC;
            end else begin
              state    <= S_ADD;
              fadd_req <= 1'b1;
              fadd_a   <= acc;
              fadd_b   <= fmul_res;
            end
          end
        end

        S_ADD: begin
          if (fadd_take) begin
            state     <= S_RESP;
            fadd_req  <= 1'b0;
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_data  <= fadd_res;
          end
        end

        S_IACC: begin
          state     <= S_RESP;
          res_valid <= 1'b1;
          res_err   <= 1'b0;
          res_data  <= acc + prod;
        end

        S_RESP: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cfu_seq : directed + randomized checks of cfu_seq against a real-valued model | rev 1.0
// ---------------------------------------------------------------------------
module tb_cfu_seq;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        flush = 1'b0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [2:0]  ins_funct3 = 3'd0;
  logic [31:0] ins_rs1 = 32'd0;
  logic [31:0] ins_rs2 = 32'd0;
  logic [31:0] ins_acc = 32'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic        fadd_req;
  logic [31:0] fadd_a;
  logic [31:0] fadd_b;
  logic        fadd_ack = 1'b0;
  logic [31:0] fadd_res = 32'd0;
  logic        fmul_req;
  logic        fmul_int;
  logic [31:0] fmul_a;
  logic [31:0] fmul_b;
  logic        fmul_ack = 1'b0;
  logic [31:0] fmul_res = 32'd0;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // ack arrives in req cycle number *_dly (1 = first cycle); 0 = never
  int add_dly = 1;
  int mul_dly = 1;
  int add_cnt = 0;
  int mul_cnt = 0;
  bit inject  = 1'b0;

  cfu_seq #(.TIMEOUT(TMO)) dut (
    .clk(clk), .n_reset(n_reset), .flush(flush),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_funct3(ins_funct3),
    .ins_rs1(ins_rs1), .ins_rs2(ins_rs2), .ins_acc(ins_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .fadd_req(fadd_req), .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_ack(fadd_ack), .fadd_res(fadd_res),
    .fmul_req(fmul_req), .fmul_int(fmul_int), .fmul_a(fmul_a), .fmul_b(fmul_b),
    .fmul_ack(fmul_ack), .fmul_res(fmul_res), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no end, expected finish");
    $fatal(1, "bench time limit");
  end

  // ---- single-precision helpers (normals and zero only) ----
  function automatic real to_r(input logic [31:0] x);
    real m;
    if (x[30:23] == 8'd0) return 0.0;
    m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (real'(x[30:23]) - 127.0));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] to_sp(input real v);
    real    a, s, rem;
    int     e;
    longint f;
    logic   sgn;
    if (v == 0.0) return 32'h0;
    sgn = (v < 0.0);
    a   = sgn ? -v : v;
    e   = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    s   = a * 8388608.0;
    f   = longint'($floor(s));
    rem = s - real'(f);
    if (rem > 0.5 || (rem == 0.5 && f[0])) f++;
    if (f == 64'd16777216) begin f = 64'd8388608; e++; end
    return {sgn, 8'(e + 127), f[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    return {r[31], 8'($urandom_range(134, 120)), r[22:0]};
  endfunction

  // Reference: rd + (rs1 - rs2)^2, each operation rounded to single precision
  function automatic logic [31:0] dsqa_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] d, p;
    d = to_sp(to_r(a) - to_r(b));
    p = to_sp(to_r(d) * to_r(d));
    return to_sp(to_r(c) + to_r(p));
  endfunction

  function automatic logic [31:0] mac_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] x, y;
    x = {16'd0, a[15:0]};
    y = {16'd0, b[15:0]};
    return c + x * y;
  endfunction

  // ---- behavioural FP adder / multiplier with programmable ack delay ----
  always @(negedge clk) begin
    if (fadd_req) begin
      add_cnt++;
      fadd_ack = (add_cnt == add_dly);
      fadd_res = fadd_ack ? to_sp(to_r(fadd_a) + to_r(fadd_b)) : $urandom;
    end else begin
      add_cnt  = 0;
      fadd_ack = 1'b0;
      fadd_res = $urandom;
    end
    if (fmul_req) begin
      mul_cnt++;
      fmul_ack = (mul_cnt == mul_dly);
      if (fmul_int) fmul_res = fmul_ack ? ({16'd0, fmul_a[15:0]} * {16'd0, fmul_b[15:0]}) : $urandom;
      else          fmul_res = fmul_ack ? to_sp(to_r(fmul_a) * to_r(fmul_b)) : $urandom;
    end else begin
      mul_cnt  = 0;
      fmul_ack = inject;
      fmul_res = $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctl"}, {26'd0, res_valid, res_err, fadd_req, fmul_req, fmul_int, busy}, 32'd0);
    check({tag, " data"}, res_data, 32'd0);
    check({tag, " ops"}, fadd_a | fadd_b | fmul_a | fmul_b, 32'd0);
    check({tag, " ins_ready"}, {31'd0, ins_ready}, 32'd1);
  endtask

  // Issue one instruction, measure latency from the acceptance edge, apply backpressure, retire.
  task automatic run_ins(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input int exp_lat,
                         input logic [31:0] exp_data, input logic exp_err, input int hold,
                         input bit late);
    int cyc;
    bit seen;
    @(negedge clk);
    check({tag, " ins_ready"}, {31'd0, ins_ready}, 32'd1);
    ins_valid = 1'b1; ins_funct3 = f3; ins_rs1 = a; ins_rs2 = b; ins_acc = c;
    @(posedge clk); #1;
    ins_valid = 1'b0; ins_funct3 = 3'($urandom); ins_rs1 = $urandom; ins_rs2 = $urandom; ins_acc = $urandom;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, " busy"}, {31'd0, busy}, 32'd1);
      if (res_valid) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " data"}, res_data, exp_data);
    check({tag, " err"}, {31'd0, res_err}, {31'd0, exp_err});
    check({tag, " req_idle"}, {30'd0, fadd_req, fmul_req}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      inject = late && (h == 0);
      @(negedge clk);
      check({tag, " hold"}, {res_valid, res_err, ins_ready, 29'd0}, {1'b1, exp_err, 1'b0, 29'd0});
      check({tag, " hold data"}, res_data, exp_data);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    inject    = 1'b0;
    @(negedge clk);
    check({tag, " retire"}, {29'd0, res_valid, ins_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    logic [31:0] a, b, c, ed;
    logic [2:0]  f3;
    int          kind, lat, hold;
    bit          any_valid;

    // reset state
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // DSQA directed, zero-wait units
    run_ins("dsqa0", 3'd2, 32'h420A3D71, 32'h0, 32'h0, 4, 32'h44954C99, 1'b0, 0, 1'b0);
    run_ins("dsqa_chain", 3'd2, 32'h41F48F5C, 32'h41F88F5C, 32'h44954C99, 4, 32'h44955499, 1'b0, 1, 1'b0);
    add_dly = 3; mul_dly = 3;
    run_ins("dsqa_slow", 3'd2, 32'h41F48F5C, 32'h41F88F5C, 32'h44954C99, 10, 32'h44955499, 1'b0, 0, 1'b0);
    add_dly = 1; mul_dly = 1;

    // MAC16 with wrap
    run_ins("mac_a", 3'd0, 32'h00010005, 32'hFFFF0007, 32'h3, 3, 32'h00000026, 1'b0, 0, 1'b0);
    run_ins("mac_wrap", 3'd0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFF0, 3, 32'hFFFDFFF1, 1'b0, 0, 1'b0);

    // Illegal funct3 with 5 cycles of backpressure
    run_ins("illegal", 3'd3, 32'h11111111, 32'h22222222, 32'h12345678, 1, 32'h12345678, 1'b1, 5, 1'b0);

    // Timeout in MUL, then a late ack while responding
    mul_dly = 0;
    run_ins("timeout", 3'd0, 32'h00000009, 32'h00000007, 32'hCAFEF00D, 1 + TMO, 32'hCAFEF00D, 1'b1, 2, 1'b1);
    mul_dly = 1;

    // Flush beats acceptance
    @(negedge clk);
    flush = 1'b1; ins_valid = 1'b1; ins_funct3 = 3'd2;
    #1;
    check("flush_accept ins_ready", {31'd0, ins_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; ins_valid = 1'b0;
    @(negedge clk);
    check("flush_accept busy", {31'd0, busy}, 32'd0);

    // Flush during MUL
    mul_dly = 0;
    @(negedge clk);
    ins_valid = 1'b1; ins_funct3 = 3'd0; ins_rs1 = 32'd3; ins_rs2 = 32'd4; ins_acc = 32'd5;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_mul req", {31'd0, fmul_req}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_mul idle", {27'd0, busy, fmul_req, res_valid, res_err, ins_ready}, 32'd1);
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid) any_valid = 1'b1;
    end
    check("flush_mul no_result", {31'd0, any_valid}, 32'd0);
    mul_dly = 1;
    run_ins("after_flush", 3'd2, 32'h420A3D71, 32'h0, 32'h0, 4, 32'h44954C99, 1'b0, 0, 1'b0);

    // Asynchronous reset during ADD
    @(negedge clk);
    ins_valid = 1'b1; ins_funct3 = 3'd2; ins_rs1 = 32'h420A3D71; ins_rs2 = 32'h0; ins_acc = 32'h0;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_add in_add", {30'd0, fadd_req, busy}, 32'd3);
    #2;
    n_reset = 1'b0;
    #1;
    check_reset_outputs("rst_add");
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_add_release");
    run_ins("after_rst", 3'd0, 32'h00010005, 32'hFFFF0007, 32'h3, 3, 32'h00000026, 1'b0, 0, 1'b0);

    // Randomized mix against the reference model
    for (int i = 0; i < 24; i++) begin
      kind    = $urandom_range(2, 0);
      add_dly = $urandom_range(4, 1);
      mul_dly = $urandom_range(4, 1);
      hold    = $urandom_range(3, 0);
      if (kind == 0) begin
        a = rnd_fp(); b = rnd_fp(); c = rnd_fp();
        f3 = 3'd2;
        ed = dsqa_ref(a, b, c);
        lat = 1 + 2 * add_dly + mul_dly;
        run_ins("rnd_dsqa", f3, a, b, c, lat, ed, 1'b0, hold, 1'b0);
      end else if (kind == 1) begin
        a = $urandom; b = $urandom; c = $urandom;
        f3 = 3'd0;
        ed = mac_ref(a, b, c);
        lat = 2 + mul_dly;
        run_ins("rnd_mac", f3, a, b, c, lat, ed, 1'b0, hold, 1'b0);
      end else begin
        a = $urandom; b = $urandom; c = $urandom;
        f3 = 3'($urandom_range(7, 3));
        if ($urandom_range(1, 0) == 1) f3 = 3'd1;
        run_ins("rnd_illegal", f3, a, b, c, 1, c, 1'b1, hold, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
